// File: rtl/bp_mem_cmd_limiter_if.sv
// Handshake bundle between the processor-side port and the memory model for bp_mem_cmd_limiter.
// "slave" is the limiter's own view; "master" is the environment that drives it.
interface bp_mem_cmd_limiter_if #(
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 128,
    parameter int max_outstanding_p = 4,
    parameter int stat_width_p      = 32
);
    localparam int count_width_lp = $clog2(max_outstanding_p + 1);

    logic [cmd_width_p-1:0]    cmd_i;
    logic                      cmd_v_i;
    logic                      cmd_ready_o;
    logic [cmd_width_p-1:0]    cmd_o;
    logic                      cmd_v_o;
    logic                      cmd_ready_i;
    logic [resp_width_p-1:0]   resp_i;
    logic                      resp_v_i;
    logic                      resp_yumi_o;
    logic [resp_width_p-1:0]   resp_o;
    logic                      resp_v_o;
    logic                      resp_yumi_i;
    logic                      drain_i;
    logic                      drained_o;
    logic [count_width_lp-1:0] outstanding_o;
    logic                      err_o;
    logic [stat_width_p-1:0]   stall_cycles_o;

    modport slave (
        input  cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_v_i, resp_yumi_i, drain_i,
        output cmd_ready_o, cmd_o, cmd_v_o, resp_yumi_o, resp_o, resp_v_o,
               drained_o, outstanding_o, err_o, stall_cycles_o
    );

    modport master (
        output cmd_i, cmd_v_i, cmd_ready_i, resp_i, resp_v_i, resp_yumi_i, drain_i,
        input  cmd_ready_o, cmd_o, cmd_v_o, resp_yumi_o, resp_o, resp_v_o,
               drained_o, outstanding_o, err_o, stall_cycles_o
    );
endinterface

// File: rtl/bp_mem_cmd_limiter.sv
// Command buffer + in-flight limiter with drain handshake between the processor and bp_mem.
// Define BP_MEM_CMD_LIMITER_STATS_EN to build the saturating stall-cycle counter.
module bp_mem_cmd_limiter #(
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 128,
    parameter int fifo_els_p        = 2,
    parameter int max_outstanding_p = 4,
    parameter int stat_width_p      = 32
) (
    input logic clk_i,
    input logic reset_i,
    bp_mem_cmd_limiter_if.slave bus
);
    localparam int ptr_width_lp   = $clog2(fifo_els_p);
    localparam int fcnt_width_lp  = $clog2(fifo_els_p + 1);
    localparam int count_width_lp = $clog2(max_outstanding_p + 1);

    typedef enum logic [1:0] {E_RUN, E_DRAIN, E_DRAINED} state_e;

    state_e state_r, state_n;

    logic [cmd_width_p-1:0]    mem_r [fifo_els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
    logic [fcnt_width_lp-1:0]  fifo_cnt_r;
    logic [count_width_lp-1:0] outstanding_r;
    logic                      err_r;

    logic full, empty, enq, issue, retire, at_limit;

    assign full     = (fifo_cnt_r == fcnt_width_lp'(fifo_els_p));
    assign empty    = (fifo_cnt_r == '0);
    assign at_limit = (outstanding_r == count_width_lp'(max_outstanding_p));

    // No bypass: a full buffer refuses a new command even in a cycle it issues.
    assign bus.cmd_ready_o = ~full & ~reset_i;
    assign bus.cmd_v_o     = ~empty & ~at_limit & (state_r == E_RUN);
    assign bus.cmd_o       = mem_r[rd_ptr_r];

    assign enq    = bus.cmd_v_i & bus.cmd_ready_o;
    assign issue  = bus.cmd_v_o & bus.cmd_ready_i;
    assign retire = bus.resp_v_i & bus.resp_yumi_i;

    assign bus.resp_o      = resp_width_p'(bus.resp_i);
    assign bus.resp_v_o    = bus.resp_v_i;
    assign bus.resp_yumi_o = bus.resp_yumi_i;

    assign bus.outstanding_o = outstanding_r;
    assign bus.err_o         = err_r;

    // NOTE: storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= bus.cmd_i;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (enq)
                wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + ptr_width_lp'(1);
            if (issue)
                rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + ptr_width_lp'(1);
            if (enq & ~issue)
                fifo_cnt_r <= fifo_cnt_r + fcnt_width_lp'(1);
            else if (issue & ~enq)
                fifo_cnt_r <= fifo_cnt_r - fcnt_width_lp'(1);
        end
    end

    // A retire with nothing in flight is a protocol error; the count floors at zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_r <= '0;
            err_r         <= 1'b0;
        end else if (issue & ~retire) begin
            outstanding_r <= outstanding_r + count_width_lp'(1);
        end else if (retire & ~issue) begin
            if (outstanding_r == '0)
                err_r <= 1'b1;
            else
                outstanding_r <= outstanding_r - count_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= E_RUN;
        else         state_r <= state_n;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_n       = state_r;
        bus.drained_o = 1'b0;
        unique case (state_r)
            E_RUN: begin
                if (bus.drain_i) state_n = E_DRAIN;
            end
            E_DRAIN: begin
                if (!bus.drain_i)            state_n = E_RUN;
                else if (outstanding_r == '0) state_n = E_DRAINED;
            end
            E_DRAINED: begin
                bus.drained_o = 1'b1;
                if (!bus.drain_i) state_n = E_RUN;
            end
            default: state_n = E_RUN;
        endcase
    end

`ifdef BP_MEM_CMD_LIMITER_STATS_EN
    logic [stat_width_p-1:0] stall_cycles_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            stall_cycles_r <= '0;
        else if (~empty & (state_r == E_RUN) & at_limit & (stall_cycles_r != '1))
            stall_cycles_r <= stall_cycles_r + stat_width_p'(1);
    end

    assign bus.stall_cycles_o = stall_cycles_r;
`else
    assign bus.stall_cycles_o = {stat_width_p{1'b0}};
`endif
endmodule

// File: tb/tb_bp_mem_cmd_limiter.sv
// Directed + random bench for bp_mem_cmd_limiter against a queue-based reference model.
// Stall-count expectations follow BP_MEM_CMD_LIMITER_STATS_EN.
module tb_bp_mem_cmd_limiter;
    localparam int cmd_w    = 128;
    localparam int resp_w   = 128;
    localparam int fifo_els = 2;
    localparam int max_out  = 4;
    localparam int stat_w   = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bp_mem_cmd_limiter_if #(
        .cmd_width_p(cmd_w), .resp_width_p(resp_w),
        .max_outstanding_p(max_out), .stat_width_p(stat_w)
    ) bus ();

    bp_mem_cmd_limiter #(
        .cmd_width_p(cmd_w), .resp_width_p(resp_w), .fifo_els_p(fifo_els),
        .max_outstanding_p(max_out), .stat_width_p(stat_w)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: buffered commands, in-flight count, sticky error, stall count, drain phase.
    logic [cmd_w-1:0]  m_q[$];
    int                m_out;
    bit                m_err;
    logic [stat_w-1:0] m_stall;
    int                m_phase;   // 0 running, 1 waiting to drain, 2 drained
    bit                last_enq;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [cmd_w-1:0] rnd_cmd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [stat_w-1:0] exp_stall();
`ifdef BP_MEM_CMD_LIMITER_STATS_EN
        return m_stall;
`else
        return '0;
`endif
    endfunction

    task automatic idle_inputs();
        bus.cmd_i       = '0;
        bus.cmd_v_i     = 1'b0;
        bus.cmd_ready_i = 1'b0;
        bus.resp_i      = '0;
        bus.resp_v_i    = 1'b0;
        bus.resp_yumi_i = 1'b0;
        bus.drain_i     = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out   = 0;
        m_err   = 1'b0;
        m_stall = '0;
        m_phase = 0;
    endtask

    // One clock: check outputs at the negedge, advance the model, return just after the posedge.
    task automatic cycle();
        bit exp_ready, exp_v, enq, issue, retire;
        @(negedge clk);
        exp_ready = (m_q.size() < fifo_els);
        exp_v     = (m_q.size() > 0) && (m_out < max_out) && (m_phase == 0);
        check("cmd_ready_o", bus.cmd_ready_o, exp_ready);
        check("cmd_v_o", bus.cmd_v_o, exp_v);
        if (exp_v) check("cmd_o", bus.cmd_o, m_q[0]);
        check("outstanding_o", bus.outstanding_o, m_out);
        check("err_o", bus.err_o, m_err);
        check("drained_o", bus.drained_o, m_phase == 2);
        check("stall_cycles_o", bus.stall_cycles_o, exp_stall());
        check("resp_o", bus.resp_o, bus.resp_i);
        check("resp_pass", {bus.resp_v_o, bus.resp_yumi_o}, {bus.resp_v_i, bus.resp_yumi_i});

        enq    = bus.cmd_v_i && exp_ready;
        issue  = exp_v && bus.cmd_ready_i;
        retire = bus.resp_v_i && bus.resp_yumi_i;
        if (m_q.size() > 0 && m_phase == 0 && m_out == max_out && m_stall != '1) m_stall++;
        case (m_phase)
            0: if (bus.drain_i) m_phase = 1;
            1: if (!bus.drain_i) m_phase = 0; else if (m_out == 0) m_phase = 2;
            default: if (!bus.drain_i) m_phase = 0;
        endcase
        if (issue) void'(m_q.pop_front());
        if (enq) m_q.push_back(bus.cmd_i);
        if (issue && !retire) m_out++;
        else if (retire && !issue) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
        end
        last_enq = enq;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [cmd_w-1:0] head;
        int n;
        int guard;
        logic [stat_w-1:0] stall_snap;

        idle_inputs();
        model_reset();
        do_reset();
        cycle();   // reset-state outputs via model

        // Single command round trip
        bus.cmd_ready_i = 1'b1;
        bus.cmd_v_i = 1'b1; bus.cmd_i = rnd_cmd();
        cycle();
        bus.cmd_v_i = 1'b0;
        check("t1_v_after_accept", bus.cmd_v_o, 1'b1);
        cycle();
        check("t1_outstanding", bus.outstanding_o, 1);
        bus.resp_v_i = 1'b1; bus.resp_yumi_i = 1'b1; bus.resp_i = rnd_cmd();
        cycle();
        bus.resp_v_i = 1'b0; bus.resp_yumi_i = 1'b0;
        check("t1_retired", bus.outstanding_o, 0);

        // Six commands against a limit of four
        do_reset();
        bus.cmd_ready_i = 1'b1;
        n = 0; guard = 0;
        bus.cmd_v_i = 1'b1; bus.cmd_i = rnd_cmd();
        while (n < 6 && guard < 50) begin
            cycle();
            guard++;
            if (last_enq) begin n++; bus.cmd_i = rnd_cmd(); end
        end
        bus.cmd_v_i = 1'b0;
        check("t2_accepted", n, 6);
        cycle();
        check("t2_limit", bus.outstanding_o, max_out);
        check("t2_blocked", {bus.cmd_v_o, bus.cmd_ready_o}, 2'b00);
        stall_snap = bus.stall_cycles_o;
        repeat (3) cycle();
`ifdef BP_MEM_CMD_LIMITER_STATS_EN
        check("t2_stall_rise", bus.stall_cycles_o - stall_snap, 3);
`else
        check("t2_stall_zero", bus.stall_cycles_o | stall_snap, 0);
`endif
        bus.resp_v_i = 1'b1; bus.resp_yumi_i = 1'b1;
        cycle();
        bus.resp_v_i = 1'b0; bus.resp_yumi_i = 1'b0;
        check("t2_fifth_issue", bus.cmd_v_o, 1'b1);
        cycle();
        check("t2_back_at_limit", bus.outstanding_o, max_out);

        // Simultaneous issue and retire, then retire with nothing in flight
        do_reset();
        bus.cmd_ready_i = 1'b1;
        bus.cmd_v_i = 1'b1; bus.cmd_i = rnd_cmd(); cycle();
        bus.cmd_i = rnd_cmd(); cycle();
        bus.cmd_v_i = 1'b0; cycle();
        check("t3_two", bus.outstanding_o, 2);
        bus.cmd_v_i = 1'b1; bus.cmd_i = rnd_cmd(); cycle();
        bus.cmd_v_i = 1'b0;
        check("t3_issue_pending", bus.cmd_v_o, 1'b1);
        bus.resp_v_i = 1'b1; bus.resp_yumi_i = 1'b1;
        cycle();
        check("t3_same_cycle", bus.outstanding_o, 2);
        cycle(); cycle();
        check("t3_zero", {bus.err_o, bus.outstanding_o}, 0);
        cycle();
        bus.resp_v_i = 1'b0; bus.resp_yumi_i = 1'b0;
        check("t3_err", {bus.err_o, bus.outstanding_o}, {1'b1, 3'd0});
        cycle();

        // Drain with three in flight and one buffered
        do_reset();
        bus.cmd_ready_i = 1'b1;
        bus.cmd_v_i = 1'b1;
        repeat (3) begin bus.cmd_i = rnd_cmd(); cycle(); end
        bus.cmd_v_i = 1'b0; cycle();
        check("t4_three", bus.outstanding_o, 3);
        bus.drain_i = 1'b1; bus.cmd_v_i = 1'b1; bus.cmd_i = rnd_cmd();
        cycle();
        bus.cmd_v_i = 1'b0;
        cycle();
        check("t4_no_issue", bus.cmd_v_o, 1'b0);
        bus.resp_v_i = 1'b1; bus.resp_yumi_i = 1'b1;
        repeat (3) cycle();
        bus.resp_v_i = 1'b0; bus.resp_yumi_i = 1'b0;
        guard = 0;
        while (!bus.drained_o && guard < 10) begin cycle(); guard++; end
        check("t4_drained", {bus.drained_o, bus.cmd_v_o}, 2'b10);
        bus.drain_i = 1'b0;
        cycle();
        check("t4_resume", bus.cmd_v_o, 1'b1);
        cycle();

        // Back-pressure from memory with a full buffer
        do_reset();
        bus.cmd_v_i = 1'b1; head = rnd_cmd(); bus.cmd_i = head; cycle();
        bus.cmd_i = rnd_cmd(); cycle();
        bus.cmd_v_i = 1'b0;
        repeat (10) begin
            cycle();
            check("t5_hold", bus.cmd_o, head);
        end
        bus.cmd_ready_i = 1'b1;
        repeat (3) cycle();
        check("t5_released", bus.outstanding_o, 2);

        // Asynchronous reset mid-burst
        do_reset();
        bus.cmd_ready_i = 1'b1; bus.cmd_v_i = 1'b1;
        repeat (5) begin bus.cmd_i = rnd_cmd(); cycle(); end
        #2;
        reset = 1'b1;
        #1;
        check("t6_async", {bus.cmd_ready_o, bus.cmd_v_o, bus.outstanding_o, bus.err_o, bus.drained_o}, 0);
        check("t6_stall", bus.stall_cycles_o, 0);
        model_reset();
        idle_inputs();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        cycle();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.cmd_v_i     = $urandom_range(0, 1);
            bus.cmd_i       = rnd_cmd();
            bus.cmd_ready_i = ($urandom_range(0, 3) != 0);
            bus.resp_i      = rnd_cmd();
            bus.resp_v_i    = (m_out > 0) && ($urandom_range(0, 2) == 0);
            bus.resp_yumi_i = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) bus.drain_i = ~bus.drain_i;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
